// File: rtl/pad_ctrl_pkg.sv
// Shared types for the bidir pad bank arbiter: FSM states and the per-bank
// pad configuration word with its safe (undriven) value.
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } pad_arb_state_e;

    // Field order matches the {cs,sl,pu,pd} nibble each requester supplies.
    typedef struct packed {
        logic cs;
        logic sl;
        logic pu;
        logic pd;
    } pad_cfg_t;

    localparam pad_cfg_t PAD_CFG_SAFE = '{cs: 1'b0, sl: 1'b0, pu: 1'b0, pd: 1'b0};

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible request at or after ptr, wrapping,
// with any requester in exclude removed from consideration.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  exclude,
    output logic [PW-1:0] idx,
    output logic          valid
);

    logic [N-1:0]  elig;
    logic [PW-1:0] cand;

    // NOTE: every variable gets a default before the loop so no path infers a latch.
    always_comb begin
        elig  = req & ~exclude;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!valid && elig[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bidir_pad_arbiter.sv
// Round-robin owner arbitration of the bidir pad bank, with a tristate
// turnaround window between owners and an optional hold timeout.
`ifndef NUM_BIDIR_PADS
`define NUM_BIDIR_PADS 8
`endif

module bidir_pad_arbiter
    import pad_ctrl_pkg::*;
#(
    parameter int NUM_BIDIR_PADS = `NUM_BIDIR_PADS,
    parameter int NUM_REQ        = 4,
    parameter int TURN_CYCLES    = 2,
    parameter int MAX_HOLD       = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_REQ-1:0]                revoked,
    input  logic [NUM_REQ*NUM_BIDIR_PADS-1:0] req_out,
    input  logic [NUM_REQ*NUM_BIDIR_PADS-1:0] req_oe,
    input  logic [NUM_REQ*4-1:0]              req_cfg,
    output logic [NUM_BIDIR_PADS-1:0]         req_in,
    input  logic [NUM_BIDIR_PADS-1:0]         bidir_in,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_out,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_pd,
    output logic                              busy
);

    localparam int W  = NUM_BIDIR_PADS;
    localparam int N  = NUM_REQ;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("bidir_pad_arbiter: NUM_REQ must be >= 2");
    end
    if (TURN_CYCLES < 1) begin : g_bad_turn
        $error("bidir_pad_arbiter: TURN_CYCLES must be >= 1");
    end

    pad_arb_state_e state_q, state_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic           owner_vld_q, owner_vld_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [N-1:0]   revoked_q, revoked_d;
    logic [W-1:0]   out_q, out_d;
    logic [W-1:0]   oe_q, oe_d;
    pad_cfg_t       cfg_q, cfg_d;
    logic [W-1:0]   req_in_q, req_in_d;

    logic [N-1:0]   owner_oh;
    logic           others_req;
    logic           timeout;
    logic           own_exit;
    logic [PW-1:0]  ptr_after_own;
    logic [PW-1:0]  pick_ptr;
    logic [N-1:0]   pick_excl;
    logic [PW-1:0]  pick_idx;
    logic           pick_valid;

    assign owner_oh      = N'(1) << owner_q;
    assign others_req    = |(req & ~owner_oh);
    assign timeout       = (MAX_HOLD != 0) && (hcnt_q == HW'(MAX_HOLD - 1)) && others_req;
    assign own_exit      = (state_q == OWN) && (!req[owner_q] || timeout);
    assign ptr_after_own = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

    // On OWN exit the next winner is chosen past the old owner, which is excluded.
    assign pick_ptr  = (state_q == OWN) ? ptr_after_own : ptr_q;
    assign pick_excl = (state_q == OWN) ? owner_oh : '0;

    rr_pick #(.N(N), .PW(PW)) u_rr_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        ptr_d       = ptr_q;
        tcnt_d      = tcnt_q;
        hcnt_d      = '0;
        revoked_d   = '0;
        out_d       = '0;
        oe_d        = '0;
        cfg_d       = PAD_CFG_SAFE;
        req_in_d    = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d     = pick_idx;
                    owner_vld_d = 1'b1;
                    tcnt_d      = '0;
                    state_d     = TURN;
                end
            end
            TURN: begin
                if (tcnt_q == TW'(TURN_CYCLES - 1)) begin
                    tcnt_d  = '0;
                    state_d = (owner_vld_q && req[owner_q]) ? OWN : IDLE;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            OWN: begin
                if (own_exit) begin
                    revoked_d   = (timeout && req[owner_q]) ? owner_oh : '0;
                    ptr_d       = ptr_after_own;
                    owner_d     = pick_idx;
                    owner_vld_d = pick_valid;
                    tcnt_d      = '0;
                    state_d     = TURN;
                end else begin
                    out_d    = req_out[owner_q*W +: W];
                    oe_d     = req_oe[owner_q*W +: W];
                    cfg_d    = pad_cfg_t'(req_cfg[owner_q*4 +: 4]);
                    req_in_d = bidir_in;
                    if (others_req) begin
                        hcnt_d = (hcnt_q != '1) ? hcnt_q + 1'b1 : hcnt_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            ptr_q       <= '0;
            tcnt_q      <= '0;
            hcnt_q      <= '0;
            revoked_q   <= '0;
            out_q       <= '0;
            oe_q        <= '0;
            cfg_q       <= PAD_CFG_SAFE;
            req_in_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            ptr_q       <= ptr_d;
            tcnt_q      <= tcnt_d;
            hcnt_q      <= hcnt_d;
            revoked_q   <= revoked_d;
            out_q       <= out_d;
            oe_q        <= oe_d;
            cfg_q       <= cfg_d;
            req_in_q    <= req_in_d;
        end
    end

    assign gnt       = (state_q == OWN) ? owner_oh : '0;
    assign revoked   = revoked_q;
    assign busy      = (state_q != IDLE);
    assign req_in    = req_in_q;
    assign bidir_out = out_q;
    assign bidir_oe  = oe_q;
    assign bidir_cs  = {W{cfg_q.cs}};
    assign bidir_sl  = {W{cfg_q.sl}};
    assign bidir_pu  = {W{cfg_q.pu}};
    assign bidir_pd  = {W{cfg_q.pd}};
    assign bidir_ie  = '1;

endmodule

// File: tb/tb_bidir_pad_arbiter.sv
// Directed bench for bidir_pad_arbiter: 8 pads, 4 requesters,
// 2 turnaround cycles, 8-cycle hold limit.
module tb_bidir_pad_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TC = 2;
    localparam int MH = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req, gnt, revoked;
    logic [N*W-1:0] req_out, req_oe;
    logic [N*4-1:0] req_cfg;
    logic [W-1:0]   req_in, bidir_in, bidir_out, bidir_oe;
    logic [W-1:0]   bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic           busy;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic [N-1:0] prev_gnt = '0;

    always #5 clk = ~clk;

    bidir_pad_arbiter #(
        .NUM_BIDIR_PADS (W),
        .NUM_REQ        (N),
        .TURN_CYCLES    (TC),
        .MAX_HOLD       (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .revoked   (revoked),
        .req_out   (req_out),
        .req_oe    (req_oe),
        .req_cfg   (req_cfg),
        .req_in    (req_in),
        .bidir_in  (bidir_in),
        .bidir_out (bidir_out),
        .bidir_oe  (bidir_oe),
        .bidir_cs  (bidir_cs),
        .bidir_sl  (bidir_sl),
        .bidir_ie  (bidir_ie),
        .bidir_pu  (bidir_pu),
        .bidir_pd  (bidir_pd),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous properties, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (!$onehot0(gnt)) begin
                bad++;
                $display("FAIL gnt_onehot0: gnt=%b", gnt);
            end
            total++;
            if (gnt !== '0 && busy !== 1'b1) begin
                bad++;
                $display("FAIL gnt_outside_own: gnt=%b busy=%b", gnt, busy);
            end
            if (gnt !== prev_gnt) begin
                total++;
                if (bidir_oe !== '0) begin
                    bad++;
                    $display("FAIL oe_after_gnt_change: oe=%h want 00 (gnt %b->%b)", bidir_oe, prev_gnt, gnt);
                end
            end
        end
        prev_gnt = gnt;
    end

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_out = '0; req_oe = '0; req_cfg = '0; bidir_in = '0;
        tick(); tick();
        total++; if (gnt !== '0)     begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        total++; if (revoked !== '0) begin bad++; $display("FAIL rst_revoked: got %b want 0000", revoked); end
        total++; if (req_in !== '0)  begin bad++; $display("FAIL rst_req_in: got %h want 00", req_in); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (bidir_out !== '0 || bidir_oe !== '0) begin
            bad++; $display("FAIL rst_pads: out=%h oe=%h want 00/00", bidir_out, bidir_oe); end
        total++; if (bidir_ie !== 8'hFF || bidir_cs !== '0 || bidir_sl !== '0 || bidir_pu !== '0 || bidir_pd !== '0) begin
            bad++; $display("FAIL rst_cfg: ie=%h cs=%h sl=%h pu=%h pd=%h want ff/00/00/00/00",
                            bidir_ie, bidir_cs, bidir_sl, bidir_pu, bidir_pd); end
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_first_grant();
        req_out[7:0] = 8'hA5; req_oe[7:0] = 8'hFF; req_cfg[3:0] = 4'b1010; bidir_in = 8'h3C;
        req = 4'b0001;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fg_busy: got %b want 1", busy); end
        total++; if (gnt !== '0)    begin bad++; $display("FAIL fg_turn1_gnt: got %b want 0000", gnt); end
        tick();
        total++; if (gnt !== '0)    begin bad++; $display("FAIL fg_turn2_gnt: got %b want 0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL fg_gnt: got %b want 0001", gnt); end
        total++; if (bidir_oe !== '0) begin bad++; $display("FAIL fg_oe_at_gnt: got %h want 00", bidir_oe); end
        tick();
        total++; if (bidir_out !== 8'hA5) begin bad++; $display("FAIL fg_out: got %h want a5", bidir_out); end
        total++; if (bidir_oe !== 8'hFF)  begin bad++; $display("FAIL fg_oe: got %h want ff", bidir_oe); end
        total++; if (bidir_cs !== 8'hFF || bidir_sl !== 8'h00 || bidir_pu !== 8'hFF || bidir_pd !== 8'h00 || bidir_ie !== 8'hFF) begin
            bad++; $display("FAIL fg_cfg: cs=%h sl=%h pu=%h pd=%h ie=%h want ff/00/ff/00/ff",
                            bidir_cs, bidir_sl, bidir_pu, bidir_pd, bidir_ie); end
        total++; if (req_in !== 8'h3C) begin bad++; $display("FAIL fg_req_in: got %h want 3c", req_in); end
        req_out[7:0] = 8'h5A;
        tick();
        total++; if (bidir_out !== 8'h5A) begin bad++; $display("FAIL fg_latency: got %h want 5a", bidir_out); end
    endtask

    task automatic test_release();
        req = '0;
        tick();
        total++; if (gnt !== '0)      begin bad++; $display("FAIL rel_gnt: got %b want 0000", gnt); end
        total++; if (bidir_oe !== '0) begin bad++; $display("FAIL rel_oe: got %h want 00", bidir_oe); end
        total++; if (revoked !== '0)  begin bad++; $display("FAIL rel_revoked: got %b want 0000", revoked); end
        total++; if (req_in !== '0)   begin bad++; $display("FAIL rel_req_in: got %h want 00", req_in); end
        total++; if (busy !== 1'b1)   begin bad++; $display("FAIL rel_busy1: got %b want 1", busy); end
        tick();
        total++; if (busy !== 1'b1)   begin bad++; $display("FAIL rel_busy2: got %b want 1", busy); end
        tick();
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rel_idle: got %b want 0", busy); end
    endtask

    task automatic test_turn_dropout();
        int n;
        req = 4'b0100;
        tick();
        req = '0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_turn: busy=%b want 1", busy); end
        tick();
        total++; if (gnt !== '0)    begin bad++; $display("FAIL drop_gnt: got %b want 0000", gnt); end
        tick();
        total++; if (busy !== 1'b0 || gnt !== '0) begin
            bad++; $display("FAIL drop_idle: busy=%b gnt=%b want 0/0000", busy, gnt); end
        // Pointer is still 1 from the last release, so 0101 must go to requester 2.
        req = 4'b0101;
        n = 0;
        while (gnt === '0 && n < 10) begin tick(); n++; end
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL drop_ptr: gnt=%b want 0100", gnt); end
        total++; if (n !== 1 + TC)    begin bad++; $display("FAIL drop_ptr_lat: cycles=%0d want %0d", n, 1 + TC); end
        req = '0;
        tick(); tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_ptr_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_out = {8'h44, 8'h33, 8'h22, 8'h11};
        req_oe  = '1;
        req_cfg = '0;
        req     = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            int           exp_i, g, h;
            logic [N-1:0] exp_oh, prev_oh;
            logic [W-1:0] exp_d;
            exp_i   = t % N;
            exp_oh  = 4'b0001 << exp_i;
            prev_oh = 4'b0001 << ((t + N - 1) % N);
            exp_d   = 8'((exp_i + 1) * 17);
            g = 0;
            while (gnt === '0 && g < 20) begin
                if (t > 0 && g == 0) begin
                    total++; if (revoked !== prev_oh) begin
                        bad++; $display("FAIL rr_revoked t%0d: got %b want %b", t, revoked, prev_oh); end
                end
                if (g == 1) begin
                    total++; if (revoked !== '0) begin
                        bad++; $display("FAIL rr_revoked_pulse t%0d: got %b want 0000", t, revoked); end
                end
                total++; if (bidir_oe !== '0) begin
                    bad++; $display("FAIL rr_gap_oe t%0d: got %h want 00", t, bidir_oe); end
                g++;
                tick();
            end
            total++; if (g !== ((t == 0) ? 1 + TC : TC)) begin
                bad++; $display("FAIL rr_gap t%0d: cycles=%0d want %0d", t, g, (t == 0) ? 1 + TC : TC); end
            total++; if (gnt !== exp_oh) begin
                bad++; $display("FAIL rr_order t%0d: gnt=%b want %b", t, gnt, exp_oh); end
            h = 0;
            while (gnt !== '0 && h < 20) begin
                if (h > 0) begin
                    total++; if (bidir_out !== exp_d || bidir_oe !== 8'hFF) begin
                        bad++; $display("FAIL rr_pads t%0d: out=%h oe=%h want %h/ff", t, bidir_out, bidir_oe, exp_d); end
                end
                total++; if (revoked !== '0) begin
                    bad++; $display("FAIL rr_revoked_own t%0d: got %b want 0000", t, revoked); end
                h++;
                tick();
            end
            total++; if (h !== MH) begin
                bad++; $display("FAIL rr_tenure t%0d: cycles=%0d want %0d", t, h, MH); end
        end
        total++; if (revoked !== 4'b0001) begin
            bad++; $display("FAIL rr_last_revoked: got %b want 0001", revoked); end
        req = '0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_own();
        int n;
        req_oe = '1;
        req    = 4'b0001;
        n = 0;
        while (gnt === '0 && n < 10) begin tick(); n++; end
        tick();
        total++; if (bidir_oe !== 8'hFF) begin bad++; $display("FAIL rmo_pre_oe: got %h want ff", bidir_oe); end
        rst_n = 1'b0;
        tick();
        total++; if (bidir_oe !== '0)    begin bad++; $display("FAIL rmo_oe: got %h want 00", bidir_oe); end
        total++; if (bidir_ie !== 8'hFF) begin bad++; $display("FAIL rmo_ie: got %h want ff", bidir_ie); end
        total++; if (gnt !== '0)         begin bad++; $display("FAIL rmo_gnt: got %b want 0000", gnt); end
        total++; if (revoked !== '0)     begin bad++; $display("FAIL rmo_revoked: got %b want 0000", revoked); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmo_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        req   = '0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_grant();
        test_release();
        test_turn_dropout();
        test_round_robin();
        test_reset_mid_own();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
